// File: rtl/apb_rr_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  // Read data reported on a timed-out transfer (sliced to DATA_W at use).
  localparam logic [63:0] TIMEOUT_RDATA = 64'd0;

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester after the
// last-granted index wins, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               valid_o
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;
  logic          hit_s;

  // Walk candidates ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first eligible one is taken.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s         = {1'b0, ptr_i} + (PW+1)'(i);
      cand_s        = (sum_s >= (PW+1)'(NUM_REQ)) ? (sum_s[PW-1:0] - PW'(NUM_REQ))
                                                  : sum_s[PW-1:0];
      hit_s         = !valid_o && eligible_i[cand_s];
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      idx_o         = hit_s ? cand_s : idx_o;
      valid_o       = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one slave between NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing and a pready timeout.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;

  logic [NUM_REQ-1:0]   eligible_s;
  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [PW-1:0]        arb_idx_s;
  logic                 arb_valid_s;

  // A requester showing done this cycle is masked so it cannot be granted twice.
  assign eligible_s = req_i & ~done_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .eligible_i (eligible_s),
    .ptr_i      (ptr_q),
    .gnt_o      (arb_gnt_s),
    .idx_o      (arb_idx_s),
    .valid_o    (arb_valid_s)
  );

  // Next-state and output computation for the IDLE/SETUP/ACCESS sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d   = ST_SETUP;
          ptr_d     = arb_idx_s;
          gnt_d     = arb_gnt_s;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = req_addr_i[int'(arb_idx_s)*ADDR_W +: ADDR_W];
          pwrite_d  = req_write_i[arb_idx_s];
          pwdata_d  = req_write_i[arb_idx_s] ? req_wdata_i[int'(arb_idx_s)*DATA_W +: DATA_W]
                                             : pwdata_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // pready wins over the timeout, including in the final allowed cycle.
        if (pready_i) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = '0;
          done_d    = gnt_q;
          rdata_d   = pwrite_q ? rdata_q : prdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = '0;
          done_d    = gnt_q;
          err_d     = 1'b1;
          rdata_d   = TIMEOUT_RDATA[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the pointer resets so requester 0 is first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= PW'(NUM_REQ - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign paddr_o   = paddr_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Scenario-driven bench for apb_rr_master; completions are checked against a
// scoreboard queue filled as each request is driven.
module tb_apb_rr_master;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, req_write_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    gnt_o, done_o;
  logic            err_o, psel_o, penable_o, pwrite_o, pready_i;
  logic [DW-1:0]   rdata_o, pwdata_o, prdata_i;
  logic [AW-1:0]   paddr_o;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .psel_o(psel_o),
    .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            cyc    = 0;
  logic [DW-1:0] exp_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t         e;
    logic [N-1:0] want;
    if (done_o !== '0) begin
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: done_o=%b with no transfer pending", done_o);
      end else begin
        e    = sb.pop_front();
        want = N'(1) << e.idx;
        if (done_o !== want || err_o !== e.err || rdata_o !== e.rdata)
          $display("FAIL completion: done=%b err=%b rdata=%h, expected done=%b err=%b rdata=%h",
                   done_o, err_o, rdata_o, want, e.err, e.rdata);
        else
          n_pass++;
      end
    end
  end

  task automatic push_exp(input int idx, input logic err, input logic [DW-1:0] rd);
    exp_t e;
    e.idx = idx; e.err = err; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_i[k]               = 1'b1;
    req_write_i[k]         = wr;
    req_addr_i[k*AW +: AW] = a;
    req_wdata_i[k*DW +: DW] = d;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_o !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    pready_i = 1'b0; prdata_i = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({gnt_o, done_o, err_o, psel_o, penable_o, pwrite_o} !== '0)
      $display("FAIL reset_ctrl: gnt=%b done=%b err=%b psel=%b pen=%b pwrite=%b, expected all 0",
               gnt_o, done_o, err_o, psel_o, penable_o, pwrite_o);
    else n_pass++;
    n_chk++;
    if (rdata_o !== '0 || paddr_o !== '0 || pwdata_o !== '0)
      $display("FAIL reset_data: rdata=%h paddr=%h pwdata=%h, expected 0", rdata_o, paddr_o, pwdata_o);
    else n_pass++;
    rst = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    n_chk++;
    if (psel_o !== 1'b0 || gnt_o !== '0)
      $display("FAIL idle_no_req: psel=%b gnt=%b, expected 0/00", psel_o, gnt_o);
    else n_pass++;
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 4'h3, 32'hA5A5_0001);
    pready_i = 1'b1;
    push_exp(0, 1'b0, exp_rdata);
    @(negedge clk);
    n_chk++;
    if (psel_o !== 1'b1 || penable_o !== 1'b0 || gnt_o !== 2'b01 || paddr_o !== 4'h3 ||
        pwrite_o !== 1'b1 || pwdata_o !== 32'hA5A5_0001)
      $display("FAIL wr_setup: psel=%b pen=%b gnt=%b addr=%h wr=%b wdata=%h, expected 1 0 01 3 1 a5a50001",
               psel_o, penable_o, gnt_o, paddr_o, pwrite_o, pwdata_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (psel_o !== 1'b1 || penable_o !== 1'b1 || done_o !== '0)
      $display("FAIL wr_access: psel=%b pen=%b done=%b, expected 1 1 00", psel_o, penable_o, done_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done_o !== 2'b01 || psel_o !== 1'b0 || penable_o !== 1'b0)
      $display("FAIL wr_done: done=%b psel=%b pen=%b, expected 01 0 0", done_o, psel_o, penable_o);
    else n_pass++;
    req_i[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done_o !== '0 || gnt_o !== '0)
      $display("FAIL wr_pulse: done=%b gnt=%b, expected 00 00", done_o, gnt_o);
    else n_pass++;
  endtask

  task automatic test_read_wait();
    set_req(1, 1'b0, 4'hC, '0);
    pready_i = 1'b0;
    prdata_i = 32'hDEAD_BEEF;
    exp_rdata = 32'h1234_5678;
    push_exp(1, 1'b0, exp_rdata);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (psel_o !== 1'b1 || penable_o !== 1'b1 || done_o !== '0 || paddr_o !== 4'hC)
        $display("FAIL rd_wait%0d: psel=%b pen=%b done=%b addr=%h, expected 1 1 00 c",
                 i, psel_o, penable_o, done_o, paddr_o);
      else n_pass++;
    end
    @(negedge clk);
    pready_i = 1'b1;
    prdata_i = 32'h1234_5678;
    @(negedge clk);
    n_chk++;
    if (done_o !== 2'b10)
      $display("FAIL rd_done: done=%b, expected 10", done_o);
    else n_pass++;
    req_i[1] = 1'b0;
    prdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    n_chk++;
    if (rdata_o !== 32'h1234_5678)
      $display("FAIL rd_hold: rdata=%h, expected 12345678", rdata_o);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit ok;
    int prev;
    prdata_i = 32'hCAFE_0000;
    pready_i = 1'b1;
    set_req(0, 1'b1, 4'h1, 32'h1111_0000);
    set_req(1, 1'b0, 4'h2, '0);
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 1) exp_rdata = 32'hCAFE_0000;
      push_exp(t % 2, 1'b0, exp_rdata);
    end
    prev = cyc;
    for (int t = 0; t < 6; t++) begin
      wait_done(8, ok);
      n_chk++;
      if (!ok || cyc - prev != 3)
        $display("FAIL rr_spacing%0d: seen=%0d gap=%0d cycles, expected seen=1 gap=3", t, ok, cyc - prev);
      else n_pass++;
      prev = cyc;
    end
    req_i = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    int acc;
    int start;
    set_req(0, 1'b0, 4'h5, '0);
    pready_i = 1'b0;
    exp_rdata = '0;
    push_exp(0, 1'b1, exp_rdata);
    acc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o !== '0) begin
        ok = 1'b1;
        break;
      end
      if (psel_o === 1'b1 && penable_o === 1'b1) acc++;
    end
    n_chk++;
    if (!ok || acc != TO)
      $display("FAIL to_cycles: seen=%0d access_cycles=%0d, expected seen=1 cycles=%0d", ok, acc, TO);
    else n_pass++;
    n_chk++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || gnt_o !== '0)
      $display("FAIL to_release: psel=%b pen=%b gnt=%b, expected 0 0 00", psel_o, penable_o, gnt_o);
    else n_pass++;
    req_i[0] = 1'b0;
    set_req(1, 1'b1, 4'h9, 32'h5A5A_5A5A);
    pready_i = 1'b1;
    push_exp(1, 1'b0, exp_rdata);
    start = cyc;
    wait_done(6, ok);
    n_chk++;
    if (!ok || cyc - start != 3)
      $display("FAIL to_recover: seen=%0d latency=%0d, expected seen=1 latency=3", ok, cyc - start);
    else n_pass++;
    req_i = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    set_req(0, 1'b0, 4'h7, '0);
    pready_i = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (penable_o !== 1'b1)
      $display("FAIL rm_pre: penable=%b, expected 1", penable_o);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({gnt_o, done_o, err_o, psel_o, penable_o} !== '0 || rdata_o !== '0 || paddr_o !== '0)
      $display("FAIL rm_outputs: gnt=%b done=%b err=%b psel=%b pen=%b rdata=%h addr=%h, expected all 0",
               gnt_o, done_o, err_o, psel_o, penable_o, rdata_o, paddr_o);
    else n_pass++;
    rst = 1'b0;
    exp_rdata = 32'h4444_0000;
    prdata_i  = 32'h4444_0000;
    pready_i  = 1'b1;
    set_req(1, 1'b1, 4'hE, 32'h7777_0000);
    push_exp(0, 1'b0, exp_rdata);
    push_exp(1, 1'b0, exp_rdata);
    @(negedge clk);
    n_chk++;
    if (gnt_o !== 2'b01)
      $display("FAIL rm_first: gnt=%b, expected 01", gnt_o);
    else n_pass++;
    wait_done(6, ok);
    req_i[0] = 1'b0;
    wait_done(6, ok);
    n_chk++;
    if (!ok || done_o !== 2'b10)
      $display("FAIL rm_second: seen=%0d done=%b, expected 1 10", ok, done_o);
    else n_pass++;
    req_i[1] = 1'b0;
  endtask

  task automatic test_rerequest();
    bit ok;
    int d1;
    @(negedge clk);
    set_req(0, 1'b1, 4'h2, 32'h2222_0000);
    pready_i = 1'b1;
    push_exp(0, 1'b0, exp_rdata);
    push_exp(0, 1'b0, exp_rdata);
    wait_done(6, ok);
    d1 = cyc;
    @(negedge clk);
    n_chk++;
    if (gnt_o !== '0 || psel_o !== 1'b0)
      $display("FAIL rr_mask: gnt=%b psel=%b after done, expected 00 0", gnt_o, psel_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (gnt_o !== 2'b01 || psel_o !== 1'b1)
      $display("FAIL rr_regrant: gnt=%b psel=%b, expected 01 1", gnt_o, psel_o);
    else n_pass++;
    wait_done(6, ok);
    n_chk++;
    if (!ok || cyc - d1 != 4)
      $display("FAIL rr_second_done: seen=%0d gap=%0d, expected 1 4", ok, cyc - d1);
    else n_pass++;
    req_i = '0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (psel_o !== 1'b0 || gnt_o !== '0)
      $display("FAIL rr_quiet: psel=%b gnt=%b, expected 0 00", psel_o, gnt_o);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_rerequest();
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: %0d completions outstanding, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
APB master that shares the 16-word APB register slave between NUM_REQ local requesters using round-robin arbitration. It sequences each granted request through the APB SETUP and ACCESS phases and waits for pready_i. It returns read data, completion and error status to the requester that was served, and enforces a pready timeout so a stuck slave cannot lock the bus.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 4, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 16, max ACCESS cycles without pready_i before abort (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_i  in  NUM_REQ  per-requester transfer request, held until own done_o bit seen
req_write_i  in  NUM_REQ  1=write, 0=read, per requester
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_REQ*DATA_W  packed write data, same packing
gnt_o  out  NUM_REQ  one-hot, requester currently owning the bus
done_o  out  NUM_REQ  one-cycle completion pulse to served requester
err_o  out  1  high with done_o when transfer aborted by timeout
rdata_o  out  DATA_W  read data of last completed read
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB ready

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; timeout counter 0; last-grant pointer = NUM_REQ-1, so requester 0 has first priority. Reset asserted mid-transfer: psel_o/penable_o drop at that edge; no done_o for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible = req_i & ~done_o. If any bit is eligible, pick the first set bit searching from last_grant+1 with wrap-around. Register gnt_o, paddr_o, pwrite_o, pwdata_o (wdata only if write) and the pointer, then go to SETUP. If no bit is eligible, stay in IDLE.
- SETUP (1 cycle): psel_o=1, penable_o=0; go to ACCESS.
- ACCESS: psel_o=1, penable_o=1; the counter increments each cycle with pready_i=0.
  - pready_i=1: next edge -> IDLE, psel_o=penable_o=0, gnt_o=0, done_o[g]=1 for 1 cycle, err_o=0. On a read, rdata_o<=prdata_i; on a write, rdata_o is held.
  - Counter reaches TIMEOUT_CYC-1 with pready_i=0: next edge -> IDLE, done_o[g]=1, err_o=1, rdata_o<=0.
  - pready_i=1 in the final timeout cycle counts as success.
- Latency: zero-wait transfer = req_i sampled in IDLE at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done_o in cycle 3. Back-to-back minimum is 3 cycles per transfer.
- APB outputs (paddr_o, pwrite_o, pwdata_o) are stable from SETUP through end of ACCESS. Requester inputs are sampled only in IDLE; later changes are ignored.
- The requester showing done_o is masked that cycle, which prevents a double grant. It may keep req_i high to request again and competes normally afterwards.
- Simultaneous requests: strict round-robin. A requester re-requesting waits at most NUM_REQ-1 grants.
- req_i deasserted before the grant: it is not served. After the grant it is ignored; the transfer completes.

Decomposition:
- Package apb_rr_pkg: state enum (IDLE, SETUP, ACCESS), default ADDR_W/DATA_W, timeout error rdata constant (0).
- Sub-module rr_arbiter: eligible vector plus pointer in, one-hot grant and valid out. Combinational rotate/priority; the pointer register stays in the top.

Test Plan:
- Single write: req_i=01, addr 4'h3, wdata 32'hA5A5_0001, pready_i tied 1 -> psel_o cycle 1, penable_o cycle 2, done_o=01 cycle 3, err_o=0, rdata_o unchanged.
- Read with wait states: req 1 reads 4'hC, pready_i low 3 ACCESS cycles, then high with prdata_i=32'h1234_5678 -> done_o=10 after 4th ACCESS cycle, rdata_o=32'h1234_5678.
- Contention: both req_i held high for 6 transfers -> grant order 0,1,0,1,0,1; each done_o pulse 1 cycle; no gap beyond 3 cycles per transfer.
- Timeout: pready_i stuck 0 -> exactly 16 ACCESS cycles, then done_o pulse with err_o=1, rdata_o=0, psel_o=0; the next request is served normally.
- Reset mid-ACCESS: assert rst during wait state -> next edge all outputs 0, no done_o; after release, requester 0 wins a simultaneous request.
- Re-request masking: requester 0 keeps req_i high through done_o with requester 1 idle -> regranted only in the cycle after done_o, one transfer per done.
